// File: rtl/mult_div_unit.sv
// Iterative HI/LO multiply/divide unit for the execute stage.
// A multiply or divide runs for 32 cycles on operand magnitudes. A final
// cycle then applies the result signs and writes HI/LO.
module mult_div_unit #(
    parameter int                 DATA_W  = 32,
    parameter logic [DATA_W-1:0]  DIV0_LO = 32'hFFFFFFFF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [1:0]        op,
    input  logic [DATA_W-1:0] src_a,
    input  logic [DATA_W-1:0] src_b,
    input  logic              hi_we,
    input  logic              lo_we,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo,
    output logic              busy,
    output logic              done
);

    localparam int ACC_W = 2 * DATA_W;
    localparam int CNT_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(DATA_W - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } stateType;

    stateType          state;
    stateType          nextState;
    logic              opDiv;
    logic              negQuot;
    logic              negRem;
    logic [DATA_W-1:0] rawA;
    logic [DATA_W-1:0] opA;
    logic [DATA_W-1:0] opB;
    logic [ACC_W-1:0]  acc;
    logic [CNT_W-1:0]  count;

    logic [DATA_W:0]   mulSum;
    logic [DATA_W:0]   divShifted;
    logic [DATA_W:0]   divDiff;
    logic              divBit;
    logic [DATA_W-1:0] divRem;
    logic [DATA_W-1:0] magA;
    logic [DATA_W-1:0] magB;
    logic [ACC_W-1:0]  result;

    // State register; reset abandons any operation in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Next-state and busy decode: one capture edge, 32 iteration edges, one write-back edge.
    always_comb begin
        nextState = state;
        busy      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    nextState = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (count == LAST_COUNT) begin
                    nextState = FIN;
                end
            end
            FIN: begin
                busy      = 1'b1;
                nextState = IDLE;
            end
            default: begin
                nextState = IDLE;
            end
        endcase
    end

    // Per-iteration arithmetic: add-shift multiply step and restoring divide step.
    always_comb begin
        magA       = (!op[0] && src_a[DATA_W-1]) ? -src_a : src_a;
        magB       = (!op[0] && src_b[DATA_W-1]) ? -src_b : src_b;
        mulSum     = {1'b0, acc[ACC_W-1:DATA_W]} + (opB[0] ? {1'b0, opA} : {(DATA_W+1){1'b0}});
        divShifted = {acc[ACC_W-1:DATA_W], opA[DATA_W-1]};
        divDiff    = divShifted - {1'b0, opB};
        divBit     = ~divDiff[DATA_W];
        divRem     = divBit ? divDiff[DATA_W-1:0] : divShifted[DATA_W-1:0];
    end

    // Sign correction and divide-by-zero override applied in the final cycle.
    always_comb begin
        result = acc;
        if (opDiv) begin
            if (opB == '0) begin
                result = {rawA, DIV0_LO};
            end else begin
                result[DATA_W-1:0]     = negQuot ? -acc[DATA_W-1:0] : acc[DATA_W-1:0];
                result[ACC_W-1:DATA_W] = negRem ? -acc[ACC_W-1:DATA_W] : acc[ACC_W-1:DATA_W];
            end
        end else if (negQuot) begin
            result = -acc;
        end
    end

    // Datapath: operand capture, iteration, HI/LO write-back and MTHI/MTLO.
    always_ff @(posedge clk) begin
        if (reset) begin
            hi      <= '0;
            lo      <= '0;
            done    <= 1'b0;
            opDiv   <= 1'b0;
            negQuot <= 1'b0;
            negRem  <= 1'b0;
            rawA    <= '0;
            opA     <= '0;
            opB     <= '0;
            acc     <= '0;
            count   <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (hi_we) begin
                        hi <= wdata;
                    end
                    if (lo_we) begin
                        lo <= wdata;
                    end
                    if (start) begin
                        opDiv   <= op[1];
                        negQuot <= !op[0] && (src_a[DATA_W-1] ^ src_b[DATA_W-1]);
                        negRem  <= !op[0] && src_a[DATA_W-1];
                        rawA    <= src_a;
                        opA     <= magA;
                        opB     <= magB;
                        acc     <= '0;
                        count   <= '0;
                    end
                end
                RUN: begin
                    count <= count + CNT_W'(1);
                    if (opDiv) begin
                        acc <= {divRem, acc[DATA_W-2:0], divBit};
                        opA <= {opA[DATA_W-2:0], 1'b0};
                    end else begin
                        acc <= {mulSum, acc[DATA_W-1:1]};
                        opB <= {1'b0, opB[DATA_W-1:1]};
                    end
                end
                FIN: begin
                    hi   <= result[ACC_W-1:DATA_W];
                    lo   <= result[DATA_W-1:0];
                    done <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed cases plus random
// operations compared against a plain-arithmetic reference model.
module tb_mult_div_unit;

    logic        clk;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        hi_we;
    logic        lo_we;
    logic [31:0] wdata;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        done;

    int          checkCount = 0;
    int          errorCount = 0;
    logic [31:0] expHi;
    logic [31:0] expLo;

    mult_div_unit #(.DATA_W(32), .DIV0_LO(32'hFFFFFFFF)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .src_a (src_a),
        .src_b (src_b),
        .hi_we (hi_we),
        .lo_we (lo_we),
        .wdata (wdata),
        .hi    (hi),
        .lo    (lo),
        .busy  (busy),
        .done  (done)
    );

    // Free-running 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Counts every comparison and reports any mismatch.
    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Reference result {hi, lo} straight from the arithmetic definition of each op.
    function automatic logic [63:0] refModel(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        longint sa;
        longint sb;
        longint q;
        longint r;
        logic [63:0] ua;
        logic [63:0] ub;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        refModel = 64'd0;
        case (o)
            2'b00: refModel = sa * sb;
            2'b01: refModel = ua * ub;
            2'b10: begin
                if (b == 32'd0) begin
                    refModel = {a, 32'hFFFFFFFF};
                end else begin
                    q = sa / sb;
                    r = sa % sb;
                    refModel = {r[31:0], q[31:0]};
                end
            end
            default: begin
                if (b == 32'd0) begin
                    refModel = {a, 32'hFFFFFFFF};
                end else begin
                    refModel = {(a % b), (a / b)};
                end
            end
        endcase
    endfunction

    // Launches an op at the current negedge and waits for done, checking latency and result.
    // With interfere set, start and lo_we are pulsed ten cycles into the operation.
    // Returns at the negedge of the done cycle.
    task automatic applyStimulus(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                 input bit interfere, input string tag);
        int cycles;
        logic [63:0] expected;
        expected = refModel(o, a, b);
        expHi = expected[63:32];
        expLo = expected[31:0];
        op    = o;
        src_a = a;
        src_b = b;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        op    = 2'($urandom_range(0, 3));
        src_a = $urandom;
        src_b = $urandom;
        cycles = 0;
        while (busy && cycles < 100) begin
            cycles++;
            if (interfere && cycles == 10) begin
                start = 1'b1;
                op    = 2'b01;
                lo_we = 1'b1;
                wdata = 32'hDEADBEEF;
            end else if (interfere && cycles == 11) begin
                start = 1'b0;
                lo_we = 1'b0;
            end
            @(negedge clk);
        end
        checkOutput({tag, "_latency"}, 64'(cycles), 64'd33);
        checkOutput({tag, "_done"}, 64'(done), 64'd1);
        checkOutput({tag, "_hi"}, 64'(hi), 64'(expHi));
        checkOutput({tag, "_lo"}, 64'(lo), 64'(expLo));
    endtask

    // One cycle after done: pulse over, unit idle, result held.
    task automatic finishOp(input string tag);
        @(negedge clk);
        checkOutput({tag, "_done_drop"}, 64'(done), 64'd0);
        checkOutput({tag, "_idle"}, 64'(busy), 64'd0);
        checkOutput({tag, "_hold"}, {hi, lo}, {expHi, expLo});
    endtask

    // Main sequence: directed cases first, then randomized operations.
    initial begin
        int doneSeen;
        int cycles;
        logic [1:0]  rOp;
        logic [31:0] rA;
        logic [31:0] rB;

        reset = 1'b1;
        start = 1'b0;
        op    = 2'b00;
        src_a = 32'd0;
        src_b = 32'd0;
        hi_we = 1'b0;
        lo_we = 1'b0;
        wdata = 32'd0;
        repeat (2) @(negedge clk);
        checkOutput("reset_hi", 64'(hi), 64'd0);
        checkOutput("reset_lo", 64'(lo), 64'd0);
        checkOutput("reset_busy", 64'(busy), 64'd0);
        checkOutput("reset_done", 64'(done), 64'd0);
        reset = 1'b0;
        @(negedge clk);

        applyStimulus(2'b00, 32'hFFFFFFFD, 32'd7, 1'b0, "mult_neg");
        checkOutput("mult_neg_hi_const", 64'(hi), 64'hFFFFFFFF);
        checkOutput("mult_neg_lo_const", 64'(lo), 64'hFFFFFFEB);
        finishOp("mult_neg");

        applyStimulus(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, "multu_max");
        checkOutput("multu_max_busy_in_done", 64'(busy), 64'd0);
        applyStimulus(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, "mult_b2b");
        checkOutput("mult_b2b_lo_const", 64'(lo), 64'd1);
        finishOp("mult_b2b");

        applyStimulus(2'b10, 32'hFFFFFFF9, 32'd2, 1'b0, "div_neg");
        finishOp("div_neg");
        applyStimulus(2'b11, 32'd100, 32'd7, 1'b0, "divu_100_7");
        finishOp("divu_100_7");
        applyStimulus(2'b10, 32'h80000000, 32'hFFFFFFFF, 1'b0, "div_ovf");
        checkOutput("div_ovf_lo_const", 64'(lo), 64'h80000000);
        finishOp("div_ovf");

        applyStimulus(2'b11, 32'd5, 32'd0, 1'b1, "divu_zero");
        finishOp("divu_zero");
        applyStimulus(2'b10, 32'hFFFFFFF0, 32'd0, 1'b0, "div_zero_neg");
        finishOp("div_zero_neg");

        hi_we = 1'b1;
        wdata = 32'h12345678;
        @(negedge clk);
        hi_we = 1'b0;
        checkOutput("mthi", 64'(hi), 64'h12345678);
        lo_we = 1'b1;
        wdata = 32'h9ABCDEF0;
        @(negedge clk);
        lo_we = 1'b0;
        checkOutput("mtlo", 64'(lo), 64'h9ABCDEF0);
        checkOutput("mtlo_hi_kept", 64'(hi), 64'h12345678);
        hi_we = 1'b1;
        lo_we = 1'b1;
        wdata = 32'h0BADF00D;
        @(negedge clk);
        hi_we = 1'b0;
        lo_we = 1'b0;
        checkOutput("mthilo_both", {hi, lo}, {32'h0BADF00D, 32'h0BADF00D});
        applyStimulus(2'b10, 32'd9, 32'd3, 1'b0, "div_9_3");
        finishOp("div_9_3");

        op    = 2'b01;
        src_a = 32'd3;
        src_b = 32'd5;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (19) @(negedge clk);
        checkOutput("abort_busy_before", 64'(busy), 64'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checkOutput("abort_busy", 64'(busy), 64'd0);
        checkOutput("abort_hilo", {hi, lo}, 64'd0);
        checkOutput("abort_done", 64'(done), 64'd0);
        doneSeen = 0;
        cycles = 0;
        while (cycles < 40) begin
            cycles++;
            if (done || busy) begin
                doneSeen++;
            end
            @(negedge clk);
        end
        checkOutput("abort_no_done", 64'(doneSeen), 64'd0);
        applyStimulus(2'b01, 32'd3, 32'd5, 1'b0, "multu_after_abort");
        finishOp("multu_after_abort");

        for (int i = 0; i < 24; i++) begin
            rOp = 2'($urandom_range(0, 3));
            rA  = $urandom;
            case ($urandom_range(0, 3))
                0:       rB = 32'd0;
                1:       rB = 32'($urandom_range(1, 15));
                2:       rB = -32'($urandom_range(1, 15));
                default: rB = $urandom;
            endcase
            applyStimulus(rOp, rA, rB, 1'b0, $sformatf("rand%0d", i));
            finishOp($sformatf("rand%0d", i));
        end

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
